jogada_sequencer: RTL
=====================

// Module: jogada_sequencer
// PURPOSE
//   Sequences one play of the game: on a gerar_nova_jogada pulse from the UC it draws a pseudo-random target LED (0..10,
//   never equal to the previous target), lights it and runs a level-dependent response window. It then reports hit or miss
//   to the UC through a one-cycle ponto_evento pulse and keeps the running score. It sits between the UC and the 11-LED array.
// PARAMETERS
//   N_LEDS      11          number of target LEDs; legal range 2..16
//   TEMPO_N0    50_000_000  response window, in clock cycles, for nivel 0
//   TEMPO_N1    37_500_000  response window, in clock cycles, for nivel 1
//   TEMPO_N2    25_000_000  response window, in clock cycles, for nivel 2
//   TEMPO_N3    12_500_000  response window, in clock cycles, for nivel 3
//   LFSR_SEED   8'hA5       LFSR reset value; must be non-zero
// PORTS
//   clock              in   1       system clock
//   reset              in   1       asynchronous, active-high
//   gerar_nova_jogada  in   1       start-play pulse from the UC; honoured only in IDLE
//   nivel              in   2       level from level_register; sampled on the accepted gerar_nova_jogada
//   acerto             in   1       player reached the lit target; already synchronised; sampled only in ESPERA
//   reset_pontos       in   1       synchronous score clear
//   leds               out  N_LEDS  one-hot target LED
//   ponto_evento       out  1       one-cycle pulse at end of play
//   acertou            out  1       result of the last play: 1 = hit, 0 = miss
//   pontos             out  8       hit counter, saturating
//   jogada_ativa       out  1       high in SORTEIA and ESPERA
//   db_estado          out  2       FSM state code
// BEHAVIOUR
//   Reset (async): state IDLE, leds = 0, ponto_evento = 0, acertou = 0, pontos = 0, lfsr = LFSR_SEED, timer = 0,
//     prev_idx = 4'hF (no previous target).
//   LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. It advances every clock in every state and is never zero.
//   State codes: IDLE = 00, SORTEIA = 01, ESPERA = 10, RESULTADO = 11.
//   IDLE: gerar_nova_jogada = 1 -> latch nivel, go to SORTEIA. gerar_nova_jogada in any other state is ignored (not queued).
//   SORTEIA: candidate cand = lfsr[3:0].
//     If cand >= N_LEDS or cand == prev_idx, stay in SORTEIA; the LFSR has advanced, so retry next cycle.
//     Otherwise: prev_idx <= cand, leds <= one-hot(cand), timer <= TEMPO_Nx(latched nivel) - 1, go to ESPERA.
//     Maximal-length LFSR bounds the retries to 255 cycles.
//   ESPERA: leds holds the one-hot target.
//     acerto = 1 -> acertou <= 1, go to RESULTADO.
//     else timer == 0 -> acertou <= 0, go to RESULTADO.
//     else timer decrements.
//     If acerto = 1 in the same cycle as timer == 0, the hit wins.
//     Window length: exactly TEMPO_Nx cycles spent in ESPERA.
//   RESULTADO: lasts one cycle.
//     ponto_evento = 1 and leds = 0 in this cycle.
//     On a hit, pontos increments, saturating at 255.
//     Go to IDLE. acertou holds until the next RESULTADO.
//   Latency: gerar_nova_jogada sampled at edge t -> SORTEIA from t+1 -> leds lit no earlier than edge t+2.
//   reset_pontos = 1 -> pontos <= 0 in any state. It takes priority over a simultaneous increment. The FSM is unaffected.
//   jogada_ativa is decoded combinationally from the state. All other outputs are registered.
//   Reset asserted mid-play: leds clear immediately (asynchronous), no ponto_evento is issued, and prev_idx returns to 4'hF.
// TESTING (bench overrides TEMPO_N0..3 = 20/15/10/5)
//   1. Reset, then nivel = 0, pulse gerar, hold acerto = 0 -> exactly one leds bit set for 20 cycles; then ponto_evento
//      pulses for 1 cycle, acertou = 0, pontos = 0, leds = 0.
//   2. nivel = 3, gerar, assert acerto on the 3rd ESPERA cycle -> ponto_evento on the next cycle, acertou = 1, pontos = 1.
//   3. 200 consecutive plays with immediate acerto -> lit index always in 0..10, never repeats back-to-back, all 11 LEDs seen,
//      pontos = 200.
//   4. Preload pontos = 255 via 255 hits, then 1 more hit -> pontos stays 255.
//      Then reset_pontos coincident with a hit -> pontos = 0.
//   5. acerto rises in the same cycle timer hits 0 (nivel 2, ESPERA cycle 10) -> acertou = 1.
//      gerar pulses issued during ESPERA -> no second play starts.
//   6. Assert reset in the middle of ESPERA -> leds = 0 at once, no ponto_evento, FSM in IDLE with db_estado = 00,
//      lfsr reloaded to 8'hA5.

Source files
------------

// File: rtl/jogada_sequencer_if.sv
// jogada_sequencer_if
//   Bundles the UC/LED-array side signals of jogada_sequencer.
//   master : the controlling side (UC / testbench) - drives play requests,
//            level, hit indication and score clear; observes results.
//   slave  : the sequencer itself.
// Signals
//   gerar_nova_jogada  start-play pulse
//   nivel[1:0]         level, sampled when a play is accepted
//   acerto             player hit the lit target (already synchronised)
//   reset_pontos       synchronous score clear
//   leds[N_LEDS-1:0]   one-hot target LED
//   ponto_evento       one-cycle end-of-play pulse
//   acertou            result of last play (1 = hit)
//   pontos[7:0]        saturating hit counter
//   jogada_ativa       play in progress (SORTEIA/ESPERA)
//   db_estado[1:0]     FSM state code for debug
interface jogada_sequencer_if #(
  parameter int N_LEDS = 11
);
  logic              gerar_nova_jogada;
  logic [1:0]        nivel;
  logic              acerto;
  logic              reset_pontos;
  logic [N_LEDS-1:0] leds;
  logic              ponto_evento;
  logic              acertou;
  logic [7:0]        pontos;
  logic              jogada_ativa;
  logic [1:0]        db_estado;

  modport master (
    output gerar_nova_jogada, nivel, acerto, reset_pontos,
    input  leds, ponto_evento, acertou, pontos, jogada_ativa, db_estado
  );

  modport slave (
    input  gerar_nova_jogada, nivel, acerto, reset_pontos,
    output leds, ponto_evento, acertou, pontos, jogada_ativa, db_estado
  );
endinterface

// File: rtl/jogada_sequencer.sv
// jogada_sequencer
//   Runs one play of the game: on a start pulse in IDLE it draws a
//   pseudo-random target LED (never the same as the previous one), lights it
//   for a level-dependent response window, then reports hit/miss with a
//   one-cycle ponto_evento pulse and keeps a saturating hit counter.
// Ports
//   clock  system clock
//   reset  asynchronous, active-high
//   bus    jogada_sequencer_if.slave (see interface header for signals)
module jogada_sequencer #(
  parameter int unsigned N_LEDS    = 11,
  parameter int unsigned TEMPO_N0  = 50_000_000,
  parameter int unsigned TEMPO_N1  = 37_500_000,
  parameter int unsigned TEMPO_N2  = 25_000_000,
  parameter int unsigned TEMPO_N3  = 12_500_000,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input logic              clock,
  input logic              reset,
  jogada_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    SORTEIA   = 2'b01,
    ESPERA    = 2'b10,
    RESULTADO = 2'b11
  } state_t;

  state_t            state;
  logic [N_LEDS-1:0] leds_q;
  logic              evt_q;
  logic              hit_q;
  logic [7:0]        pontos_q;
  logic [7:0]        lfsr;
  logic [31:0]       timer;
  logic [3:0]        prev_idx;
  logic [1:0]        nivel_q;

  logic              fb;
  logic [3:0]        cand;
  logic              cand_ok;
  logic [31:0]       window;

  // x^8+x^6+x^5+x^4+1, shifting left: maximal length, so it never reaches zero
  // from a non-zero seed and any candidate value recurs within 255 cycles.
  assign fb      = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign cand    = lfsr[3:0];
  assign cand_ok = (32'(cand) < N_LEDS) && (cand != prev_idx);

  // Timer is loaded with window-1 and the miss is declared on timer==0, which
  // gives exactly TEMPO_Nx cycles in ESPERA.
  always_comb begin
    window = 32'(TEMPO_N0 - 1);
    case (nivel_q)
      2'd0: window = 32'(TEMPO_N0 - 1);
      2'd1: window = 32'(TEMPO_N1 - 1);
      2'd2: window = 32'(TEMPO_N2 - 1);
      2'd3: window = 32'(TEMPO_N3 - 1);
      default: window = 32'(TEMPO_N0 - 1);
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      leds_q   <= '0;
      evt_q    <= 1'b0;
      hit_q    <= 1'b0;
      pontos_q <= 8'd0;
      lfsr     <= LFSR_SEED;
      timer    <= 32'd0;
      prev_idx <= 4'hF;
      nivel_q  <= 2'd0;
    end else begin
      lfsr  <= {lfsr[6:0], fb};
      evt_q <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.gerar_nova_jogada) begin
            nivel_q <= bus.nivel;
            state   <= SORTEIA;
          end
        end

        // Rejected candidates just wait for the next LFSR value.
        SORTEIA: begin
          if (cand_ok) begin
            prev_idx <= cand;
            leds_q   <= N_LEDS'(1) << cand;
            timer    <= window;
            state    <= ESPERA;
          end
        end

        // A hit is checked before the timeout so it wins on the last cycle.
        ESPERA: begin
          if (bus.acerto) begin
            hit_q  <= 1'b1;
            leds_q <= '0;
            evt_q  <= 1'b1;
            state  <= RESULTADO;
          end else if (timer == 32'd0) begin
            hit_q  <= 1'b0;
            leds_q <= '0;
            evt_q  <= 1'b1;
            state  <= RESULTADO;
          end else begin
            timer <= timer - 32'd1;
          end
        end

        RESULTADO: begin
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase

      // Score moves on the hit edge so it is already updated while
      // ponto_evento is high; a clear overrides a simultaneous hit.
      if (bus.reset_pontos)
        pontos_q <= 8'd0;
      else if (state == ESPERA && bus.acerto && pontos_q != 8'hFF)
        pontos_q <= pontos_q + 8'd1;
    end
  end

  assign bus.leds         = leds_q;
  assign bus.ponto_evento = evt_q;
  assign bus.acertou      = hit_q;
  assign bus.pontos       = pontos_q;
  assign bus.db_estado    = state;
  assign bus.jogada_ativa = (state == SORTEIA) || (state == ESPERA);

endmodule
